// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared types and constants for the LEGv8 memory stage.
//   exmem_t : contents of the EX/MEM pipeline register
//   memwb_t : contents of the MEM/WB pipeline register
//   state_t : memory-access sequencer state
//   XZR     : zero register index; writes to it are discarded
package mem_stage_pkg;

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  // "byte" is a reserved word, hence byte_acc for the LDURB/STURB flag
  typedef struct packed {
    logic        valid;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic        mem_to_reg;
    logic        byte_acc;
    logic [63:0] alu_result;
    logic [63:0] store_data;
    logic [4:0]  rd;
  } exmem_t;

  typedef struct packed {
    logic        valid;
    logic        reg_wr;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        err;
  } memwb_t;

endpackage

// File: rtl/mem_wb_stage_data_memory_array.sv
// data_memory_array
// Byte-addressed data memory, DEPTH_BYTES bytes, contents never reset.
// Ports:
//   clk   : write clock
//   we    : write enable, applied with the byte-lane mask
//   be    : 8-lane byte enable, lane i targets byte addr+i
//   addr  : byte address of lane 0
//   wdata : write data, lane i = wdata[8*i+7:8*i]
//   rdata : combinational little-endian 64-bit read starting at addr
module data_memory_array #(
  parameter int DEPTH_BYTES = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [7:0]                     be,
  input  logic [$clog2(DEPTH_BYTES)-1:0] addr,
  input  logic [63:0]                    wdata,
  output logic [63:0]                    rdata
);

  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0] mem [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (be[i]) mem[addr + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

  // Lanes past the end wrap; the stage faults such accesses so the
  // wrapped bytes are never consumed
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) begin
      rdata[8*i +: 8] = mem[addr + AW'(i)];
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
// LEGv8 MEM stage: EX/MEM register, wait-stated data memory access and
// MEM/WB register feeding register-file writeback.
// Optional feature macro: MEM_BYTE_ACCESS_EN (LDURB/STURB support).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   ex_*            : EX-stage result captured when mem_stall is low
//   mem_stall       : upstream must hold; EX/MEM not loaded this edge
//   wb_*            : MEM/WB register (valid, write enable, rd, data, fault)
//   fwd_*           : MEM-stage forwarding port for the EX forwarding mux
module mem_wb_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic        ex_reg_wr,
  input  logic        ex_mem_to_reg,
  input  logic        ex_byte,
  input  logic [63:0] ex_alu_result,
  input  logic [63:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_reg_wr,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        wb_err,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [63:0] fwd_data
);

  localparam int          AW      = $clog2(DEPTH_BYTES);
  localparam int          CW      = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [63:0] DEPTH64 = 64'(DEPTH_BYTES);

  exmem_t        x_q, x_d;
  memwb_t        w_q, w_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        commit;
  logic        is_mem;
  logic        fault;
  logic        mem_we;
  logic [7:0]  mem_be;
  logic [63:0] mem_rdata;
  logic [63:0] load_data;
  logic [63:0] result_data;
  logic        x_reg_wr;

  assign commit   = (cnt_q == '0);
  assign is_mem   = x_q.mem_rd | x_q.mem_wr;
  assign x_reg_wr = x_q.valid & x_q.reg_wr & (x_q.rd != XZR);

  // Access fault: doublewords must be 8-aligned and fit entirely inside
  // the array; the subtraction form avoids overflow on huge addresses
  always_comb begin
    fault = 1'b0;
    if (x_q.valid && is_mem) begin
`ifdef MEM_BYTE_ACCESS_EN
      if (x_q.byte_acc) begin
        fault = (x_q.alu_result >= DEPTH64);
      end else begin
        fault = (x_q.alu_result[2:0] != 3'b000) ||
                (x_q.alu_result > (DEPTH64 - 64'd8));
      end
`else
      fault = (x_q.alu_result[2:0] != 3'b000) ||
              (x_q.alu_result > (DEPTH64 - 64'd8));
`endif
    end
  end

  // Stores land at the commit edge only; reset on that edge aborts them
  always_comb begin
    mem_we = commit & x_q.valid & x_q.mem_wr & ~fault & ~reset;
`ifdef MEM_BYTE_ACCESS_EN
    mem_be = x_q.byte_acc ? 8'h01 : 8'hFF;
`else
    mem_be = 8'hFF;
`endif
  end

  data_memory_array #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .be   (mem_be),
    .addr (x_q.alu_result[AW-1:0]),
    .wdata(x_q.store_data),
    .rdata(mem_rdata)
  );

  // Load data is forced to zero on a fault so no stale bytes leak out
  always_comb begin
    load_data = '0;
    if (x_q.mem_rd && !fault) begin
`ifdef MEM_BYTE_ACCESS_EN
      load_data = x_q.byte_acc ? {56'd0, mem_rdata[7:0]} : mem_rdata;
`else
      load_data = mem_rdata;
`endif
    end
    result_data = x_q.mem_to_reg ? load_data : x_q.alu_result;
  end

  // Sequencer: capture in IDLE, count down wait states in BUSY. MEM/WB
  // takes the result only in the commit cycle, so a held entry is
  // written back exactly once
  always_comb begin
    x_d     = x_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    w_d     = '0;

    if (commit) begin
      w_d.valid  = x_q.valid;
      w_d.reg_wr = x_reg_wr;
      w_d.rd     = x_q.rd;
      w_d.data   = result_data;
      w_d.err    = fault;
    end

    case (state_q)
      IDLE: begin
        x_d = '0;
        if (ex_valid) begin
          x_d.valid      = 1'b1;
          x_d.mem_rd     = ex_mem_rd;
          x_d.mem_wr     = ex_mem_wr;
          x_d.reg_wr     = ex_reg_wr;
          x_d.mem_to_reg = ex_mem_to_reg;
          x_d.byte_acc   = ex_byte;
          x_d.alu_result = ex_alu_result;
          x_d.store_data = ex_store_data;
          x_d.rd         = ex_rd;
        end
        if (ex_valid && (ex_mem_rd || ex_mem_wr) && (LATENCY > 0)) begin
          cnt_d   = CW'(LATENCY);
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= '0;
      w_q     <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      x_q     <= x_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // A load can only forward once its data is read in the commit cycle
  assign mem_stall = (cnt_q != '0);
  assign wb_valid  = w_q.valid;
  assign wb_reg_wr = w_q.reg_wr;
  assign wb_rd     = w_q.rd;
  assign wb_data   = w_q.data;
  assign wb_err    = w_q.err;
  assign fwd_valid = x_reg_wr & (~x_q.mem_rd | commit);
  assign fwd_rd    = x_q.rd;
  assign fwd_data  = result_data;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipelined LEGv8 memory stage that consumes EX-stage results through an internal EX/MEM register.
- Performs LDUR/STUR accesses to a byte-addressed data memory with configurable wait-state latency.
- Produces the MEM/WB register that drives register-file writeback.
- Exports a stall to freeze IF/DEC/EX, plus a MEM-stage forwarding port for the EX forwarding mux.

Parameters:
DEPTH_BYTES, 1024, data memory size in bytes; power of two, at least 8
LATENCY, 2, wait cycles per load/store (0 = single-cycle memory)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
ex_valid  input  1  EX result valid (0 = bubble)
ex_mem_rd  input  1  load (LDUR/LDURB)
ex_mem_wr  input  1  store (STUR/STURB)
ex_reg_wr  input  1  instruction writes Rd
ex_mem_to_reg  input  1  writeback selects load data, else ALU result
ex_byte  input  1  byte access (LDURB/STURB); see Optional Feature
ex_alu_result  input  64  ALU result / effective address
ex_store_data  input  64  Rt value for stores
ex_rd  input  5  destination register
mem_stall  output  1  upstream must hold; EX/MEM not loaded this edge
wb_valid  output  1  MEM/WB entry valid
wb_reg_wr  output  1  regfile write enable
wb_rd  output  5  writeback register
wb_data  output  64  writeback data
wb_err  output  1  access fault for this entry
fwd_valid  output  1  MEM-stage forward available
fwd_rd  output  5  forward register
fwd_data  output  64  forward value

Behaviour:
- Reset values:
  - EX/MEM and MEM/WB cleared: valid=0, all fields 0.
  - cnt=0, state IDLE.
  - All outputs 0.
  - Memory contents are not reset.
  - Reset mid-access aborts the access; a pending store is not written.
- EX/MEM capture: at each edge with mem_stall=0, X <= inputs.
  - If ex_valid=0, X becomes a bubble.
  - A captured memory op (rd|wr, valid) loads cnt=LATENCY and enters BUSY when LATENCY>0.
- Stall signal: mem_stall = (cnt != 0), decoded from registers only; no combinational path from inputs.
  - In BUSY, cnt decrements each edge.
  - Returns to IDLE when cnt reaches 0.
- Commit cycle (cnt==0):
  - Store writes memory at that edge.
  - Load reads memory combinationally in that cycle.
  - Little-endian, address = X.alu_result.
- MEM/WB update, every edge:
  - cnt==0: W <= result of X.
  - Otherwise: W <= bubble (wb_valid=0), so no duplicate writeback.
- Latency: input accepted at edge E; wb_valid asserted after edge E+1+LATENCY. Non-memory ops take exactly one cycle.
- Writeback data: wb_data = mem_to_reg ? load data : alu_result.
- Register write gating: wb_reg_wr = valid & reg_wr & (rd != 31), since XZR is never written.
- Faults: doubleword access with addr[2:0] != 0, or any access with addr + size > DEPTH_BYTES.
  - Sets wb_err.
  - Store is suppressed.
  - Load data = 0.
  - wb_reg_wr still follows the normal rule; upstream traps on wb_err.
- Forwarding: fwd_valid = X.valid & X.reg_wr & (X.rd != 31) & (!X.mem_rd | cnt==0).
  - fwd_data uses the same mux as wb_data.
- Back-to-back memory ops: the second is captured at the edge where the first commits; cnt reloads.
- Load-after-store to the same address: the store commits first, so the load sees the new data.

Optional Feature:
- Macro: MEM_BYTE_ACCESS_EN.
- Defined:
  - ex_byte honoured.
  - LDURB zero-extends mem[addr][7:0] to 64 bits.
  - STURB writes only byte addr from ex_store_data[7:0].
  - Byte accesses are never misaligned; range fault applies when addr >= DEPTH_BYTES.
- Undefined:
  - ex_byte ignored; all accesses are 64-bit.
  - Byte-lane logic is not built.

Decomposition:
- mem_stage_pkg:
  - exmem_t struct: valid, mem_rd, mem_wr, reg_wr, mem_to_reg, byte, alu_result, store_data, rd.
  - memwb_t struct: valid, reg_wr, rd, data, err.
  - Constant XZR = 5'd31.
  - State enum {IDLE, BUSY}.
- Sub-module data_memory_array:
  - Byte-addressed, parameter DEPTH_BYTES.
  - 8-lane byte enable.
  - Synchronous write, combinational 64-bit little-endian read.

Test Plan:
- LATENCY=2, STUR X=0x1122334455667788 to addr 0x10 -> mem_stall high 2 cycles; no wb_reg_wr; mem[0x10]=0x88 … mem[0x17]=0x11.
- Then LDUR from addr 0x10, rd=5 -> wb_valid 3 cycles after accept; wb_rd=5; wb_data=0x1122334455667788; wb_err=0.
- ADD result 0x2A to rd=31 -> wb_valid=1, wb_reg_wr=0; fwd_valid=0; one-cycle latency with no stall.
- LDUR from addr 0x13 -> wb_err=1, wb_data=0; STUR to addr 0x3FC (DEPTH_BYTES=1024) -> wb_err=1, memory unchanged.
- Assert reset during a STUR BUSY cycle -> all outputs 0 the next cycle; target bytes unchanged; next op accepted normally.
- With MEM_BYTE_ACCESS_EN: STURB 0xAB to addr 0x21, then LDURB from 0x21 -> wb_data=0x00000000000000AB; neighbouring bytes unchanged.
